// File: rtl/reduce_unit.sv
// Multi-cycle bitwise reduction (AND/OR/XOR/XNOR) folding CHUNK bits per cycle.
// Optional build macro EARLY_EXIT_EN: AND/OR finish as soon as the result is decided.
module reduce_unit #(
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [1:0]   mode,
    output logic         busy,
    output logic         done,
    output logic         out,
    output logic [1:0]   o_dbg_state
);

    localparam int N  = W / CHUNK;
    localparam int CW = $clog2(N) + 1;

    generate
        if (W < 2 || (W % CHUNK) != 0) begin : g_bad_cfg
            $error("reduce_unit: W must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    localparam logic [1:0] M_AND  = 2'b00;
    localparam logic [1:0] M_OR   = 2'b01;
    localparam logic [1:0] M_XNOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_sr;
    logic [1:0]       r_mode;
    logic             r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_out;
    logic [CHUNK-1:0] w_chunk;
    logic             w_red;
    logic             w_acc_next;
    logic             w_last;

    assign w_chunk = r_sr[CHUNK-1:0];

    // XNOR folds as XOR; the inversion is applied once when the result is latched.
    always_comb begin
        w_red      = ^w_chunk;
        w_acc_next = r_acc ^ w_red;
        case (r_mode)
            M_AND: begin
                w_red      = &w_chunk;
                w_acc_next = r_acc & w_red;
            end
            M_OR: begin
                w_red      = |w_chunk;
                w_acc_next = r_acc | w_red;
            end
            default: ;
        endcase
    end

`ifdef EARLY_EXIT_EN
    assign w_last = (r_cnt == CW'(N - 1))
                  || ((r_mode == M_AND) && !w_acc_next)
                  || ((r_mode == M_OR) && w_acc_next);
`else
    assign w_last = (r_cnt == CW'(N - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr   <= '0;
            r_mode <= '0;
            r_acc  <= 1'b0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sr   <= x;
                        r_mode <= mode;
                        r_acc  <= (mode == M_AND);
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_sr  <= r_sr >> CHUNK;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    // Latch the result on the final fold so it is valid during DONE.
                    if (w_last) r_out <= w_acc_next ^ (r_mode == M_XNOR);
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign out         = r_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reduce_unit.sv
// Randomized bench for reduce_unit: main 16/4 instance plus an 8/8 single-fold instance.
module tb_reduce_unit;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int N  = W / CH;
    localparam int BW = 8;

`ifdef EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start, busy, done, out;
    logic [W-1:0] x;
    logic [1:0]   mode, dbg;
    logic          b_start, b_busy, b_done, b_out;
    logic [BW-1:0] b_x;
    logic [1:0]    b_mode, b_dbg;

    reduce_unit #(.W(W), .CHUNK(CH)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .mode(mode),
        .busy(busy), .done(done), .out(out), .o_dbg_state(dbg)
    );

    reduce_unit #(.W(BW), .CHUNK(BW)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .x(b_x), .mode(b_mode),
        .busy(b_busy), .done(b_done), .out(b_out), .o_dbg_state(b_dbg)
    );

    int   n_total = 0;
    int   n_bad   = 0;
    logic exp_q[$];
    logic last_out;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference model: reduction of the whole operand, by counting ones
    function automatic logic ref_out(input logic [31:0] v, input int w, input logic [1:0] m);
        int ones = 0;
        for (int i = 0; i < w; i++) ones += int'(v[i]);
        case (m)
            2'd0:    return ones == w;
            2'd1:    return ones != 0;
            2'd2:    return (ones % 2) == 1;
            default: return (ones % 2) == 0;
        endcase
    endfunction

    // cycles from accepting edge to done; early exit at the first deciding chunk
    function automatic int ref_lat(input logic [31:0] v, input int w, input int ch, input logic [1:0] m);
        int n = w / ch;
        for (int i = 0; i < n; i++) begin
            int ones = 0;
            for (int j = 0; j < ch; j++) ones += int'(v[i*ch + j]);
            if (EE && m == 2'd0 && ones != ch) return i + 2;
            if (EE && m == 2'd1 && ones != 0) return i + 2;
        end
        return n + 1;
    endfunction

    // driver: one operation on the main instance, called at a negedge with DUT idle
    task automatic do_op(input logic [W-1:0] xv, input logic [1:0] mv, input bit scramble);
        int   lat;
        int   done_at = 0;
        int   busy_n  = 0;
        int   done_n  = 0;
        int   overlap = 0;
        logic e;
        check_eq("hold", out, last_out);
        exp_q.push_back(ref_out(xv, W, mv));
        lat   = ref_lat(xv, W, CH, mv);
        x     = xv;
        mode  = mv;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (scramble) begin
                x    = '1;
                mode = 2'($urandom);
            end
            if (busy) busy_n++;
            if (busy && done) overlap++;
            if (done) begin
                done_n++;
                if (done_at == 0) begin
                    done_at  = c;
                    e        = exp_q.pop_front();
                    check_eq("out", out, e);
                    last_out = e;
                end
            end
        end
        check_eq("latency", done_at, lat);
        check_eq("busy_cycles", busy_n, lat - 1);
        check_eq("done_width", done_n, 1);
        check_eq("busy_done_overlap", overlap, 0);
        if (done_at == 0) exp_q.delete();
    endtask

    task automatic do_op_b(input logic [BW-1:0] xv, input logic [1:0] mv);
        int done_at = 0;
        int busy_n  = 0;
        b_x     = xv;
        b_mode  = mv;
        b_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            b_start = 1'b0;
            b_x     = 8'($urandom);
            if (b_busy) busy_n++;
            if (b_done && done_at == 0) begin
                done_at = c;
                check_eq("b_out", b_out, ref_out(32'(xv), BW, mv));
            end
        end
        check_eq("b_latency", done_at, ref_lat(32'(xv), BW, BW, mv));
        check_eq("b_busy_cycles", busy_n, 1);
    endtask

    task automatic do_continuous();
        int dones[$];
        logic e;
        x     = 16'hABCD;
        mode  = 2'd2;
        e     = ref_out(32'(x), W, mode);
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                dones.push_back(c);
                check_eq("cont_out", out, e);
            end
        end
        start = 1'b0;
        check_eq("cont_count", dones.size(), 5);
        for (int i = 1; i < dones.size(); i++) check_eq("cont_gap", dones[i] - dones[i-1], N + 2);
        repeat (8) @(negedge clk);
        last_out = e;
    endtask

    task automatic do_reset_mid_run();
        int done_n = 0;
        x     = 16'h1234;
        mode  = 2'd2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_out", out, 0);
        check_eq("rst_state", dbg, 0);
        rst      = 1'b0;
        last_out = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check_eq("rst_no_done", done_n, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] xv;
        int           r;
        rst      = 1'b1;
        start    = 1'b0;
        x        = '0;
        mode     = '0;
        b_start  = 1'b0;
        b_x      = '0;
        b_mode   = '0;
        last_out = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_out", out, 0);
        check_eq("reset_state", dbg, 0);
        check_eq("reset_b_out", {b_busy, b_done, b_out}, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'h0000, 2'd1, 1'b0);
        do_op(16'h0100, 2'd1, 1'b0);
        do_op(16'h0100, 2'd2, 1'b0);
        do_op(16'h0100, 2'd3, 1'b0);
        do_op(16'hF00F, 2'd2, 1'b0);
        do_op(16'hF00F, 2'd3, 1'b0);
        do_op(16'h7FFF, 2'd0, 1'b1);
        do_op(16'hFFF0, 2'd0, 1'b0);
        do_op(16'hFFFF, 2'd0, 1'b0);
        do_op(16'h000F, 2'd1, 1'b0);

        do_continuous();
        do_reset_mid_run();
        do_op(16'hFFFF, 2'd0, 1'b0);

        repeat (40) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       xv = '1;
                1:       xv = '0;
                2:       xv = ~(W'(1) << $urandom_range(0, W - 1));
                default: xv = W'($urandom);
            endcase
            do_op(xv, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        do_op_b(8'hFF, 2'd0);
        repeat (12) do_op_b(($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom), 2'($urandom_range(0, 3)));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/reduce_unit.md
Name: reduce_unit

Overview:
Multi-cycle, multi-mode bitwise reduction engine for the ALU datapath. Generalises the combinational AND reduction chain to a parametrised width, a selectable operator (AND/OR/XOR/XNOR) and a configurable number of bits folded per cycle. It trades latency for area on wide operands. A start/busy/done handshake lets the ALU controller sequence it.

Parameters:
W, 16, operand width in bits; must be >= 2.
CHUNK, 4, bits folded per cycle; W must be an integer multiple of CHUNK; W % CHUNK != 0 -> elaboration error.
(derived) N = W/CHUNK, number of RUN cycles; CW = $clog2(N)+1, counter width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
x  input  W  operand; captured on an accepted start.
mode  input  2  operator, captured with x: 00 AND, 01 OR, 10 XOR, 11 XNOR.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when out is updated.
out  output  1  reduction result; holds its value until the next done.

Behaviour:
- Reset: synchronous, active-high. On any rising edge with rst=1: state=IDLE, busy=0, done=0, out=0, shift register=0, accumulator=0, counter=0. Reset overrides start. Reset mid-RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, then:
  - capture x into shift register sr and mode into mreg;
  - accumulator acc = identity (1 for AND; 0 for OR, XOR and XNOR);
  - cnt = 0; next state RUN.
  - Otherwise stay in IDLE.
- RUN, once per cycle:
  - c = sr[CHUNK-1:0];
  - acc <= acc op reduce_op(c), where op is AND/OR/XOR per mreg; XNOR uses XOR internally;
  - sr <= sr >> CHUNK; cnt <= cnt+1;
  - when cnt == N-1, next state is DONE; otherwise stay in RUN.
- DONE, one cycle:
  - done=1; out = final acc, inverted for XNOR;
  - next state IDLE unconditionally.
- Latency: start accepted at edge k -> busy=1 for cycles k+1..k+N -> done=1 and out valid in cycle k+N+1. Minimum start-to-start spacing is N+2 cycles.
- start is ignored in RUN and DONE; it is not queued. A start in the DONE cycle is dropped. The next start is accepted on the first IDLE cycle.
- x and mode may change freely after capture; they do not affect an operation in flight.
- CHUNK == W (N=1): exactly one RUN cycle.
- busy and done are never high in the same cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
EARLY_EXIT_EN
- Defined:
  - In AND mode, if acc after a RUN update is 0, the next state is DONE regardless of cnt.
  - In OR mode, if acc after a RUN update is 1, the next state is DONE regardless of cnt.
  - Latency becomes variable: 2..N+1 cycles from start to done.
  - XOR/XNOR are unaffected.
- Undefined: latency is always exactly N+1 cycles.
- out values are identical in both builds.

Test Plan:
1. W=8, CHUNK=2, AND. x=8'd14 -> done 5 cycles after start, out=0. x=8'd0 -> out=0. x=8'd255 -> out=1. busy high for exactly 4 cycles each time.
2. W=16, CHUNK=4, OR/XOR/XNOR.
   - x=16'h0000: OR out=0.
   - x=16'h0100: OR out=1, XOR out=1, XNOR out=0.
   - x=16'hF00F: XOR out=0, XNOR out=1.
   - Done pulse 5 cycles after start in every case.
3. Handshake:
   - start held high continuously -> one operation per 6 cycles (W=16, CHUNK=4), done pulses exactly 1 cycle.
   - x changed to 16'hFFFF during RUN of an AND on 16'h7FFF -> out=0.
4. Reset: assert rst during the 2nd RUN cycle -> next cycle state IDLE, busy=0, done=0, out=0. No done pulse follows. A fresh start afterwards completes normally.
5. Boundary: W=CHUNK=8, AND on 8'hFF -> busy 1 cycle, done at cycle k+2, out=1. W=2, CHUNK=1 also completes correctly.
6. EARLY_EXIT_EN defined, W=16, CHUNK=4:
   - AND on 16'hFFF0 -> done at k+2, out=0.
   - AND on 16'hFFFF -> done at k+5, out=1.
   - OR on 16'h000F -> done at k+2, out=1.
   - Same vectors without the macro -> done always at k+5, same out values.
